i2s_sample_feeder: RTL and testbench
====================================

# i2s_sample_feeder

Stereo sample buffer that sits directly upstream of the I2S transmitter. It accepts 16-bit left/right sample pairs from the audio mixer over a valid/ready handshake and stores them in a small FIFO. It presents one stable pair on `left_chan`/`right_chan` per I2S frame, advancing on each rising edge of the transmitter's `lrclk`. When the FIFO underruns it either holds the last pair or mutes, and it counts the underrun events.

## Interface
Parameters:
- `AUDIO_DW`, 16, sample width per channel.
- `ADDR_W`, 4, FIFO address width; depth = 2^ADDR_W = 16 stereo entries.
- `URUN_W`, 8, width of the saturating underrun counter.

Ports:
- `clk`  in  1  system clock; same clock that drives the transmitter's divider.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous FIFO clear, active high.
- `mute_on_underrun`  in  1  1 = output zero on underrun; 0 = hold last pair.
- `in_valid`  in  1  upstream pair valid.
- `in_ready`  out  1  FIFO can accept a pair.
- `in_left`  in  AUDIO_DW  upstream left sample.
- `in_right`  in  AUDIO_DW  upstream right sample.
- `lrclk`  in  1  word-select from the transmitter (0 = left, 1 = right).
- `left_chan`  out  AUDIO_DW  registered left sample to the transmitter.
- `right_chan`  out  AUDIO_DW  registered right sample to the transmitter.
- `level`  out  ADDR_W+1  current FIFO occupancy, 0..2^ADDR_W.
- `underrun_cnt`  out  URUN_W  saturating count of underrun frames.

## Operation
- Storage: circular buffer of 2^ADDR_W entries, each 2*AUDIO_DW wide ({left,right}). Pointers are ADDR_W+1 bits; full = MSBs differ and lower bits equal; empty = pointers equal.
- Push: occurs when `in_valid && in_ready`. `in_ready = !full`, computed from the registered pointers only. A pop in the same cycle does not make room for a push into a full FIFO.
- lrclk handling: `lrclk` passes through a 2-flop synchronizer, then a third register for edge detection. `frame_tick` = sync'd high && previous low, i.e. a rising edge, the start of the right channel.
- Pop on `frame_tick`:
  - If not empty: read the head entry into `left_chan`/`right_chan` and increment the read pointer.
  - If empty: underrun. `underrun_cnt` is incremented, saturating at 2^URUN_W-1. If `mute_on_underrun`, the outputs load 0; otherwise they keep their value.
- Push and pop in the same cycle: both occur and `level` is unchanged. When empty, a same-cycle push is not visible to the pop (no bypass), so the tick counts as an underrun and the pushed pair remains stored.
- `flush`: both pointers are set to 0 and `level` to 0. Outputs and `underrun_cnt` are untouched. A push in the same cycle is dropped. A `frame_tick` in the same cycle is treated as an underrun.
- `level` is a register updated with each push/pop (+1, -1, or 0). It never exceeds 2^ADDR_W.
- Reset (async, `rst_n` low):
  - pointers, `level`, `left_chan`, `right_chan`, `underrun_cnt` = 0;
  - synchronizer and edge registers = 1, so no spurious tick on release while `lrclk` is high after the transmitter's reset;
  - `in_ready` = 1.

## Timing
- `lrclk` rise to `frame_tick`: 3 clk. `frame_tick` to updated `left_chan`/`right_chan`: 1 clk. Total: 4 clk after the `lrclk` edge as seen at `clk`.
- Outputs stay constant for one full frame (2 × prescaler sclk periods). The transmitter latches the pair at the end of the right channel, roughly half a frame after the update, so setup is guaranteed for any prescaler ≥ 2 and CLK_DIV ≥ 4.
- Push to `level` increment: 1 clk. A pushed pair is poppable from the next cycle.
- `in_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the first pop from full.
- Mid-operation reset: the FIFO contents are discarded and the outputs go to 0 immediately (asynchronously).

## Test plan
- Reset then idle with `lrclk` toggling and no pushes, `mute_on_underrun`=1 → outputs remain 0x0000/0x0000; `underrun_cnt` increments once per `lrclk` rise.
- Push pairs (0x1111,0xAAAA), (0x2222,0xBBBB), (0x3333,0xCCCC), then toggle `lrclk` → outputs update in that order, each 4 clk after an `lrclk` rise; `level` goes 3→2→1→0; no underruns.
- Push 17 pairs back-to-back with `in_valid` held → `in_ready` falls after the 16th; `level`=16; the 17th is accepted only after the first `lrclk` rise pops an entry.
- Empty FIFO, `mute_on_underrun`=0, last output 0x7FFF/0x8001, with an `lrclk` rise → outputs hold 0x7FFF/0x8001 and `underrun_cnt`+1. Repeat 300 rises with URUN_W=8 → the counter saturates at 255.
- Push on the exact cycle of `frame_tick` with the FIFO empty → underrun counted; `level`=1; the next rise delivers the pushed pair.
- `level`=5, assert `flush` for 1 clk → `level`=0, `in_ready`=1, outputs unchanged. Assert `rst_n` low mid-frame → all outputs 0 asynchronously, and no tick on release while `lrclk`=1.

Source files
------------

// File: rtl/i2s_sample_feeder.sv
// Stereo sample FIFO feeding an I2S transmitter: one {left,right} pair is
// popped per lrclk rising edge, with hold-or-mute and a saturating underrun count.
module i2s_sample_feeder #(
  parameter int unsigned AUDIO_DW = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned URUN_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                mute_on_underrun,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AUDIO_DW-1:0] in_left,
  input  logic [AUDIO_DW-1:0] in_right,
  input  logic                lrclk,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic [ADDR_W:0]     level,
  output logic [URUN_W-1:0]   underrun_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [2*AUDIO_DW-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic [AUDIO_DW-1:0] left_q, left_d;
  logic [AUDIO_DW-1:0] right_q, right_d;
  logic [URUN_W-1:0]   urun_q, urun_d;
  logic                lr_s1_q, lr_s2_q, lr_prev_q, frame_tick_q;
  logic                frame_tick_d;

  logic full, empty, push, pop, underrun;

  always_comb begin
    full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
            (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    // Flush wins over both sides: a same-cycle push is dropped and a tick is an underrun.
    push     = in_valid && !full && !flush;
    pop      = frame_tick_q && !empty && !flush;
    underrun = frame_tick_q && (empty || flush);
    frame_tick_d = lr_s2_q && !lr_prev_q;

    left_d  = left_q;
    right_d = right_q;
    if (pop) begin
      left_d  = mem_q[rd_ptr_q[ADDR_W-1:0]][2*AUDIO_DW-1:AUDIO_DW];
      right_d = mem_q[rd_ptr_q[ADDR_W-1:0]][AUDIO_DW-1:0];
    end else if (underrun && mute_on_underrun) begin
      left_d  = '0;
      right_d = '0;
    end

    urun_d = urun_q;
    if (underrun && (urun_q != '1)) begin
      urun_d = urun_q + URUN_W'(1);
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {in_left, in_right};
    end
  end

  // Synchronizer resets high so a transmitter idling with lrclk=1 gives no tick on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      left_q       <= '0;
      right_q      <= '0;
      urun_q       <= '0;
      lr_s1_q      <= 1'b1;
      lr_s2_q      <= 1'b1;
      lr_prev_q    <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      left_q       <= left_d;
      right_q      <= right_d;
      urun_q       <= urun_d;
      lr_s1_q      <= lrclk;
      lr_s2_q      <= lr_s1_q;
      lr_prev_q    <= lr_s2_q;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign in_ready     = !full;
  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign level        = level_q;
  assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Scoreboard bench for i2s_sample_feeder: expected frame outputs are queued by
// the stimulus and checked by a monitor 4 clk after each lrclk rise.
module tb_i2s_sample_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mute_on_underrun = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        lrclk = 1'b1;
  logic [15:0] left_chan, right_chan;
  logic [4:0]  level;
  logic [7:0]  underrun_cnt;

  int unsigned total = 0;
  int unsigned bad = 0;
  bit          started = 1'b0;
  logic [39:0] exp_q[$];

  i2s_sample_feeder #(.AUDIO_DW(16), .ADDR_W(4), .URUN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mute_on_underrun(mute_on_underrun),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .lrclk(lrclk), .left_chan(left_chan), .right_chan(right_chan),
    .level(level), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] pk(input logic [15:0] l, input logic [15:0] r,
                                     input logic [7:0] u);
    return {l, r, u};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs settle on the 4th clk edge after the lrclk rise.
  initial begin
    logic [39:0] e;
    wait (started);
    forever begin
      @(posedge lrclk);
      repeat (4) @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_unexpected: got %0h expected no frame",
                 {left_chan, right_chan, underrun_cnt});
      end else begin
        e = exp_q.pop_front();
        check("frame_out", {left_chan, right_chan, underrun_cnt}, e);
      end
    end
  end

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    bit ok;
    ok = 1'b0;
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // One lrclk period; optionally presents a push on the cycle frame_tick is active.
  task automatic frame(input bit tick_push, input logic [15:0] l, input logic [15:0] r);
    lrclk = 1'b0;
    repeat (8) @(posedge clk);
    #1 lrclk = 1'b1;
    repeat (3) @(posedge clk);
    if (tick_push) begin
      #1;
      in_left  = l;
      in_right = r;
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if (tick_push) in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ue;

    #13;
    check("rst_level", level, 5'd0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_out", {left_chan, right_chan}, 32'h0);
    check("rst_ucnt", underrun_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_tick_after_rst", underrun_cnt, 8'd0);
    started = 1'b1;

    // Idle with mute: outputs stay zero, one underrun per rise.
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(pk(16'h0000, 16'h0000, 8'(k)));
      frame(1'b0, '0, '0);
    end

    push(16'h1111, 16'hAAAA);
    push(16'h2222, 16'hBBBB);
    push(16'h3333, 16'hCCCC);
    check("level3", level, 5'd3);
    exp_q.push_back(pk(16'h1111, 16'hAAAA, 8'd3));
    frame(1'b0, '0, '0);
    check("level2", level, 5'd2);
    exp_q.push_back(pk(16'h2222, 16'hBBBB, 8'd3));
    frame(1'b0, '0, '0);
    check("level1", level, 5'd1);
    exp_q.push_back(pk(16'h3333, 16'hCCCC, 8'd3));
    frame(1'b0, '0, '0);
    check("level0", level, 5'd0);

    // Fill to 16; the 17th waits until the first pop frees a slot.
    for (int i = 1; i <= 16; i++) push(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    #1;
    check("full_level", level, 5'd16);
    check("full_ready", in_ready, 1'b0);
    in_left  = 16'h0111;
    in_right = 16'h0211;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("full_held_level", level, 5'd16);
    exp_q.push_back(pk(16'h0101, 16'h0201, 8'd3));
    frame(1'b0, '0, '0);
    in_valid = 1'b0;
    check("refill_level", level, 5'd16);
    check("refill_ready", in_ready, 1'b0);
    for (int i = 2; i <= 17; i++) begin
      exp_q.push_back(pk(16'h0100 + 16'(i), 16'h0200 + 16'(i), 8'd3));
      frame(1'b0, '0, '0);
    end
    check("drained_level", level, 5'd0);

    // Hold-last-pair on underrun.
    push(16'h7FFF, 16'h8001);
    exp_q.push_back(pk(16'h7FFF, 16'h8001, 8'd3));
    frame(1'b0, '0, '0);
    mute_on_underrun = 1'b0;
    exp_q.push_back(pk(16'h7FFF, 16'h8001, 8'd4));
    frame(1'b0, '0, '0);

    // Push coinciding with frame_tick on an empty FIFO: no bypass.
    exp_q.push_back(pk(16'h7FFF, 16'h8001, 8'd5));
    frame(1'b1, 16'h5A5A, 16'hA5A5);
    check("tick_push_level", level, 5'd1);
    exp_q.push_back(pk(16'h5A5A, 16'hA5A5, 8'd5));
    frame(1'b0, '0, '0);
    check("tick_push_drained", level, 5'd0);

    for (int k = 1; k <= 300; k++) begin
      ue = (5 + k > 255) ? 8'd255 : 8'(5 + k);
      exp_q.push_back(pk(16'h5A5A, 16'hA5A5, ue));
      frame(1'b0, '0, '0);
    end
    check("ucnt_saturated", underrun_cnt, 8'd255);

    for (int i = 0; i < 5; i++) push(16'hF000 + 16'(i), 16'hE000 + 16'(i));
    check("pre_flush_level", level, 5'd5);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_level", level, 5'd0);
    check("flush_ready", in_ready, 1'b1);
    check("flush_out", {left_chan, right_chan}, 32'h5A5AA5A5);
    check("flush_ucnt", underrun_cnt, 8'd255);
    mute_on_underrun = 1'b1;
    exp_q.push_back(pk(16'h0000, 16'h0000, 8'd255));
    frame(1'b0, '0, '0);

    // Asynchronous reset mid-frame with lrclk high.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", {left_chan, right_chan}, 32'h0);
    check("arst_level", level, 5'd0);
    check("arst_ucnt", underrun_cnt, 8'd0);
    check("arst_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("arst_no_tick", underrun_cnt, 8'd0);
    mute_on_underrun = 1'b0;
    exp_q.push_back(pk(16'h0000, 16'h0000, 8'd1));
    frame(1'b0, '0, '0);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
